// File: rtl/fp2int_conv.sv
// fp2int_conv: floating-point to integer converter for the River FPU.
//
// Converts an IEEE-754 binary operand (EXPW exponent bits, FRACW fraction
// bits) into a 32- or 64-bit signed or unsigned integer. Multi-cycle,
// single-issue. A start strobe accepted at edge k produces a one-cycle
// o_valid during the cycle after edge k+4.
//
// Optional feature macro: FPU_F2I_ROUNDING_EN
//   defined     : full RISC-V rounding-mode decode of i_rm
//   not defined : i_rm ignored, every conversion truncates (RTZ);
//                 inexact is still reported, latency unchanged
//
// Ports:
//   i_clk       clock
//   i_nrst      asynchronous active-low reset
//   i_ena       start strobe, sampled only while o_busy=0
//   i_a         operand {sign, exp, frac}
//   i_signed    1 = signed result, 0 = unsigned result
//   i_w32       1 = 32-bit result sign-extended to OUTW (ignored if OUTW=32)
//   i_rm        rounding mode (000 RNE, 001 RTZ, 010 RDN, 011 RUP, 100 RMM)
//   o_res       integer result, held until the next accepted start
//   o_overflow  invalid-operation flag (NV)
//   o_inexact   inexact flag (NX)
//   o_valid     one-cycle result strobe
//   o_busy      conversion in progress
module fp2int_conv #(
    parameter int EXPW  = 11,
    parameter int FRACW = 52,
    parameter int OUTW  = 64
) (
    input  logic                  i_clk,
    input  logic                  i_nrst,
    input  logic                  i_ena,
    input  logic [EXPW+FRACW:0]   i_a,
    input  logic                  i_signed,
    input  logic                  i_w32,
    input  logic [2:0]            i_rm,
    output logic [OUTW-1:0]       o_res,
    output logic                  o_overflow,
    output logic                  o_inexact,
    output logic                  o_valid,
    output logic                  o_busy
);

    localparam int MW   = FRACW + 1;          // mantissa incl. hidden bit
    localparam int FW   = MW + 64;            // aligned fixed-point width
    localparam int EW   = EXPW + 2;           // signed unbiased exponent width
    localparam int BIAS = (1 << (EXPW - 1)) - 1;

    logic [3:0] ena;
    logic       accept;

    // stage 1: latched operand and controls
    logic             s1_sign;
    logic [EXPW-1:0]  s1_exp;
    logic [MW-1:0]    s1_mant;
    logic             s1_signed;
    logic             s1_w32;
    logic [2:0]       s1_rm;

    // stage 2: classification
    logic             s2_sign;
    logic [MW-1:0]    s2_mant;
    logic             s2_signed;
    logic             s2_w32;
    logic [2:0]       s2_rm;
    logic             s2_nan;
    logic             s2_inf;
    logic             s2_big;
    logic             s2_tiny;
    logic             s2_exact_min;
    logic [6:0]       s2_sh;

    // stage 3: aligned and rounded magnitude
    logic             s3_sign;
    logic             s3_signed;
    logic             s3_w32;
    logic             s3_nan;
    logic             s3_inf;
    logic             s3_big;
    logic             s3_exact_min;
    logic [64:0]      s3_mag;
    logic             s3_inexact;

    // stage 4: saturated result
    logic [63:0]      s4_res;
    logic             s4_nv;
    logic             s4_nx;

    assign accept = i_ena & ~o_busy;

    // ---------------- stage 2 combinational classify ----------------
    logic signed [EW-1:0] e;
    logic signed [EW-1:0] ep1;
    logic signed [EW-1:0] wm1;
    logic                 frac_zero;
    logic                 c_nan;
    logic                 c_inf;
    logic                 c_big;
    logic                 c_tiny;
    logic                 c_exact_min;
    logic [6:0]           c_sh;

    always_comb begin
        e           = $signed({2'b00, s1_exp}) - $signed(EW'(BIAS));
        ep1         = e + $signed(EW'(1));
        wm1         = s1_w32 ? $signed(EW'(31)) : $signed(EW'(63));
        frac_zero   = ~|s1_mant[FRACW-1:0];
        c_nan       = (&s1_exp) & ~frac_zero;
        c_inf       = (&s1_exp) & frac_zero;
        // signed results already overflow at e = W-1; the single exception
        // (-2^(W-1) exactly) is flagged separately and passed through
        c_big       = s1_signed ? (e >= wm1) : (e > wm1);
        c_tiny      = e < $signed({EW{1'b1}});
        c_exact_min = s1_signed & s1_sign & (e == wm1) & frac_zero;
        c_sh        = (c_tiny | c_big) ? 7'd0 : ep1[6:0];
    end

    // ---------------- stage 3 combinational shift and round ----------------
    // Mantissa is shifted left by e+1 so the binary point sits MW bits up:
    // fx[FW-1:MW] is the integer part, fx[MW-1] the guard bit.
    logic [FW-1:0] fx;
    logic [63:0]   intg;
    logic          guard;
    logic          sticky;
    logic          inc;

    always_comb begin
        fx     = {64'b0, s2_mant} << s2_sh;
        intg   = fx[FW-1:MW];
        guard  = fx[MW-1];
        sticky = |fx[MW-2:0];
        if (s2_tiny) begin
            intg   = '0;
            guard  = 1'b0;
            sticky = |s2_mant;
        end
`ifdef FPU_F2I_ROUNDING_EN
        case (s2_rm)
            3'b000:  inc = guard & (sticky | intg[0]);
            3'b010:  inc = s2_sign & (guard | sticky);
            3'b011:  inc = ~s2_sign & (guard | sticky);
            3'b100:  inc = guard;
            default: inc = 1'b0;
        endcase
`else
        inc = 1'b0;
`endif
    end

`ifndef FPU_F2I_ROUNDING_EN
    logic unused_rm;
    assign unused_rm = ^s2_rm;
`endif

    // ---------------- stage 4 combinational saturate ----------------
    logic [63:0] pos_max;
    logic [63:0] neg_min;
    logic [64:0] pos_lim;
    logic [63:0] sat;
    logic [63:0] res_ext;
    logic        c_nv;
    logic        c_nx;

    always_comb begin
        // 32-bit limits only populate the low word; sign extension below
        // widens them to 64 bits
        if (s3_signed) begin
            pos_max = s3_w32 ? 64'h0000_0000_7FFF_FFFF : 64'h7FFF_FFFF_FFFF_FFFF;
            neg_min = s3_w32 ? 64'h0000_0000_8000_0000 : 64'h8000_0000_0000_0000;
        end else begin
            pos_max = s3_w32 ? 64'h0000_0000_FFFF_FFFF : '1;
            neg_min = '0;
        end
        pos_lim = {1'b0, pos_max};
        sat     = '0;
        c_nv    = 1'b0;
        c_nx    = 1'b0;
        if (s3_nan) begin
            c_nv = 1'b1;
            sat  = pos_max;
        end else if (s3_inf | (s3_big & ~s3_exact_min)) begin
            c_nv = 1'b1;
            sat  = s3_sign ? neg_min : pos_max;
        end else if (s3_exact_min) begin
            sat = neg_min;
        end else if (~s3_sign) begin
            if (s3_mag > pos_lim) begin
                c_nv = 1'b1;
                sat  = pos_max;
            end else begin
                sat  = s3_mag[63:0];
                c_nx = s3_inexact;
            end
        end else if (s3_signed) begin
            if (s3_mag > pos_lim + 65'd1) begin
                c_nv = 1'b1;
                sat  = neg_min;
            end else begin
                sat  = -s3_mag[63:0];
                c_nx = s3_inexact;
            end
        end else begin
            // unsigned negative: only a value rounding to zero is valid
            if (s3_mag != '0) begin
                c_nv = 1'b1;
            end else begin
                c_nx = s3_inexact;
            end
        end
        res_ext = s3_w32 ? {{32{sat[31]}}, sat[31:0]} : sat;
    end

    // ---------------- sequential ----------------
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            ena          <= '0;
            o_busy       <= 1'b0;
            o_valid      <= 1'b0;
            o_res        <= '0;
            o_overflow   <= 1'b0;
            o_inexact    <= 1'b0;
            s1_sign      <= 1'b0;
            s1_exp       <= '0;
            s1_mant      <= '0;
            s1_signed    <= 1'b0;
            s1_w32       <= 1'b0;
            s1_rm        <= '0;
            s2_sign      <= 1'b0;
            s2_mant      <= '0;
            s2_signed    <= 1'b0;
            s2_w32       <= 1'b0;
            s2_rm        <= '0;
            s2_nan       <= 1'b0;
            s2_inf       <= 1'b0;
            s2_big       <= 1'b0;
            s2_tiny      <= 1'b0;
            s2_exact_min <= 1'b0;
            s2_sh        <= '0;
            s3_sign      <= 1'b0;
            s3_signed    <= 1'b0;
            s3_w32       <= 1'b0;
            s3_nan       <= 1'b0;
            s3_inf       <= 1'b0;
            s3_big       <= 1'b0;
            s3_exact_min <= 1'b0;
            s3_mag       <= '0;
            s3_inexact   <= 1'b0;
            s4_res       <= '0;
            s4_nv        <= 1'b0;
            s4_nx        <= 1'b0;
        end else begin
            ena     <= {ena[2:0], accept};
            o_valid <= ena[3];
            if (accept) begin
                o_busy <= 1'b1;
            end else if (ena[3]) begin
                o_busy <= 1'b0;
            end

            if (accept) begin
                s1_sign   <= i_a[EXPW+FRACW];
                s1_exp    <= i_a[EXPW+FRACW-1:FRACW];
                s1_mant   <= {|i_a[EXPW+FRACW-1:FRACW], i_a[FRACW-1:0]};
                s1_signed <= i_signed;
                s1_w32    <= (OUTW == 32) | i_w32;
                s1_rm     <= i_rm;
            end

            if (ena[0]) begin
                s2_sign      <= s1_sign;
                s2_mant      <= s1_mant;
                s2_signed    <= s1_signed;
                s2_w32       <= s1_w32;
                s2_rm        <= s1_rm;
                s2_nan       <= c_nan;
                s2_inf       <= c_inf;
                s2_big       <= c_big;
                s2_tiny      <= c_tiny;
                s2_exact_min <= c_exact_min;
                s2_sh        <= c_sh;
            end

            if (ena[1]) begin
                s3_sign      <= s2_sign;
                s3_signed    <= s2_signed;
                s3_w32       <= s2_w32;
                s3_nan       <= s2_nan;
                s3_inf       <= s2_inf;
                s3_big       <= s2_big;
                s3_exact_min <= s2_exact_min;
                s3_mag       <= {1'b0, intg} + {64'b0, inc};
                s3_inexact   <= guard | sticky;
            end

            if (ena[2]) begin
                s4_res <= res_ext;
                s4_nv  <= c_nv;
                s4_nx  <= c_nx;
            end

            if (ena[3]) begin
                o_res      <= s4_res[OUTW-1:0];
                o_overflow <= s4_nv;
                o_inexact  <= s4_nx;
            end
        end
    end

endmodule

// File: doc/fp2int_conv.md
Name: fp2int_conv

Overview:
- Parametrised floating-point to integer converter for the River FPU.
- Successor of the fixed double-to-long unit, generalised in three ways:
  - any IEEE-754 binary format, set by exponent and fraction width;
  - 32- or 64-bit integer result;
  - all RISC-V rounding modes, with inexact and invalid flags.
- Multi-cycle, single-issue; sits beside the other fpu_d units and is started by the FPU dispatcher with a one-cycle i_ena strobe.

Parameters:
- EXPW, 11, exponent field width (8 for single, 11 for double).
- FRACW, 52, stored fraction width (23 for single, 52 for double).
- OUTW, 64, integer result width; must be 32 or 64.

Ports:
- i_clk  in  1  clock.
- i_nrst  in  1  reset, asynchronous, active-low.
- i_ena  in  1  start strobe; sampled only while o_busy=0.
- i_a  in  EXPW+FRACW+1  IEEE operand {sign, exp, frac}.
- i_signed  in  1  1 = signed result, 0 = unsigned result.
- i_w32  in  1  1 = 32-bit result sign-extended to OUTW; ignored when OUTW=32.
- i_rm  in  3  rounding mode: 000 RNE, 001 RTZ, 010 RDN, 011 RUP, 100 RMM.
- o_res  out  OUTW  integer result.
- o_overflow  out  1  invalid-operation flag (NV).
- o_inexact  out  1  inexact flag (NX).
- o_valid  out  1  one-cycle result strobe.
- o_busy  out  1  conversion in progress.

Behaviour:
- Reset values: all registers, the ena shift register and every output are 0.
- Pipeline and latency:
  - 4-cycle shift register ena[3:0]; i_ena accepted at edge k gives o_valid=1 during the cycle after edge k+4.
  - o_busy rises at edge k and falls at the same edge o_valid rises.
  - o_res and the flags hold their values until the next accepted start.
  - i_ena while o_busy=1 is ignored: no state change, no second o_valid.
- Stage 1 (latch):
  - register sign, exp and {hidden,frac}; hidden = (exp!=0).
  - register i_signed, i_w32 and i_rm.
  - effective width W = 32 if i_w32 or OUTW=32, else 64.
- Stage 2 (classify): unbiased e = exp - (2^(EXPW-1)-1).
  - NaN: exp all-ones and frac!=0.
  - Inf: exp all-ones and frac==0.
  - big: e >= W-1 when signed, e >= W when unsigned.
  - tiny: e < -1; only sticky bits survive.
- Stage 3 (shift and round):
  - align the mantissa into a (W+2)-bit integer plus guard bit, with sticky = OR of the discarded bits.
  - round-increment decision per i_rm, using sign for RDN/RUP.
  - NX = guard | sticky.
  - rm values 101-111 are treated as RTZ.
- Stage 4 (saturate):
  - negate if sign=1.
  - signed range [-2^(W-1), 2^(W-1)-1]; the exact value -2^(W-1) is legal (e = W-1, frac=0, sign=1).
  - unsigned: a negative value that rounds to 0 returns 0 with NV=0 and NX=1; a negative value that rounds to nonzero returns 0 with NV=1.
  - out-of-range after rounding, or Inf: NV=1, result saturates to max/min by sign.
  - NaN: NV=1, result = max positive (signed 2^(W-1)-1, unsigned all-ones).
  - whenever NV=1, NX=0.
  - W=32 results are sign-extended to OUTW, including unsigned results (RISC-V fcvt.wu).
- Zero and denormal inputs give 0; NX=1 for a nonzero denormal.
- Reset mid-operation: o_busy and ena clear immediately, and no o_valid follows.

Optional Feature:
- Macro: FPU_F2I_ROUNDING_EN.
- Defined: full i_rm decode as above.
- Not defined:
  - i_rm is ignored and every conversion uses RTZ; the round-increment logic is removed.
  - NX is still reported.
  - latency stays 4 cycles.

Test Plan:
- 0x3FF0000000000000 (1.0), signed, 64-bit, RTZ -> o_res=0x1, flags 0, o_valid exactly 4 cycles after the accepted i_ena.
- 0xC004000000000000 (-2.5), signed:
  - RNE -> 0xFFFFFFFFFFFFFFFE, NX=1;
  - RMM -> 0xFFFFFFFFFFFFFFFD, NX=1;
  - RUP -> 0xFFFFFFFFFFFFFFFE.
- 0x43E0000000000000 (2^63):
  - signed 64-bit -> 0x7FFFFFFFFFFFFFFF, NV=1;
  - unsigned -> 0x8000000000000000, NV=0;
  - 0xC3E0000000000000 signed -> 0x8000000000000000, NV=0.
- 0x7FF8000000000000 (NaN), unsigned, i_w32=1 -> 0xFFFFFFFFFFFFFFFF, NV=1, NX=0.
- Unsigned, RTZ:
  - 0xBFD3333333333333 (-0.3) -> 0, NV=0, NX=1;
  - 0xBFF0000000000000 (-1.0) -> 0, NV=1.
- Sequencing:
  - second i_ena during o_busy -> ignored, exactly one o_valid;
  - i_nrst pulsed low 2 cycles after start -> o_busy=0 at once, no o_valid, o_res=0.
